// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-entry front end.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  // Largest legal BCD digits for each field.
  localparam logic [3:0] HR_MAX_TENS       = 4'd2;
  localparam logic [3:0] HR_MAX_UNITS_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MAX_TENS      = 4'd5;
  localparam logic [3:0] UNITS_MAX         = 4'd9;

  // Field positions within the {H1,H0,M1,M0,S1,S0} time bus.
  localparam int FIELD_W = 8;
  localparam int HR_LSB  = 16;
  localparam int MIN_LSB = 8;
  localparam int SEC_LSB = 0;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw button, debounces it and emits a one-cycle pulse on an
// accepted press.
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic        sync0;
  logic        sync1;
  logic        level;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      level <= 1'b0;
      cnt   <= 16'd0;
      press <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      press <= 1'b0;
      // Any bounce back to the accepted level restarts the stability window.
      if (sync1 == level) begin
        cnt <= 16'd0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        level <= sync1;
        cnt   <= 16'd0;
        press <= sync1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// MODE/INC push-button time entry: edits hours then minutes, flashes the
// field being edited, and strobes load into the timekeeper on commit.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] BLINK_DIV       = 24'd12500000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [23:0] time_in,
  output logic [23:0] time_out,
  output logic        load,
  output logic        setting,
  output logic [5:0]  blank
);

  state_t      state;
  logic        mode_press;
  logic        inc_press;
  logic [23:0] blink_cnt;
  logic        phase;
  logic        blink_wrap;
  logic        phase_next;
  logic [31:0] idle_cnt;
  logic        unused_seconds;

  // Incoming seconds are always replaced by 00 on capture.
  assign unused_seconds = ^time_in[SEC_LSB +: FIELD_W];

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .btn(btn_mode), .press(mode_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .press(inc_press)
  );

  assign blink_wrap = (blink_cnt == BLINK_DIV - 24'd1);
  assign phase_next = phase ^ blink_wrap;

  function automatic logic [7:0] inc_hours(input logic [7:0] h);
    logic [3:0] t;
    logic [3:0] u;
    t = h[7:4];
    u = h[3:0];
    if (t > HR_MAX_TENS || (t == HR_MAX_TENS && u >= HR_MAX_UNITS_AT_2))
      return 8'h00;
    else if (u >= UNITS_MAX)
      return {t + 4'd1, 4'd0};
    else
      return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] inc_minutes(input logic [7:0] m);
    logic [3:0] t;
    logic [3:0] u;
    t = m[7:4];
    u = m[3:0];
    if (t > MIN_MAX_TENS || (t == MIN_MAX_TENS && u >= UNITS_MAX))
      return 8'h00;
    else if (u >= UNITS_MAX)
      return {t + 4'd1, 4'd0};
    else
      return {t, u + 4'd1};
  endfunction

  function automatic logic [5:0] blank_mask(input state_t s, input logic p);
    case (s)
      SET_HR:  return {p, p, 4'b0000};
      SET_MIN: return {2'b00, p, p, 2'b00};
      default: return 6'b000000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      time_out  <= 24'h000000;
      load      <= 1'b0;
      setting   <= 1'b0;
      blank     <= 6'b000000;
      blink_cnt <= 24'd0;
      phase     <= 1'b0;
      idle_cnt  <= 32'd0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          blink_cnt <= 24'd0;
          phase     <= 1'b0;
          idle_cnt  <= 32'd0;
          setting   <= 1'b0;
          blank     <= 6'b000000;
          if (mode_press) begin
            state    <= SET_HR;
            setting  <= 1'b1;
            time_out <= {time_in[HR_LSB +: FIELD_W], time_in[MIN_LSB +: FIELD_W], 8'h00};
          end
        end
        SET_HR, SET_MIN: begin
          blink_cnt <= blink_wrap ? 24'd0 : blink_cnt + 24'd1;
          phase     <= phase_next;
          // Mode takes priority; a coincident inc press is dropped.
          if (mode_press) begin
            idle_cnt <= 32'd0;
            if (state == SET_HR) begin
              state <= SET_MIN;
              blank <= blank_mask(SET_MIN, phase_next);
            end else begin
              state <= COMMIT;
              load  <= 1'b1;
              blank <= 6'b000000;
            end
          end else if (inc_press) begin
            idle_cnt <= 32'd0;
            blank    <= blank_mask(state, phase_next);
            if (state == SET_HR)
              time_out[HR_LSB +: FIELD_W] <= inc_hours(time_out[HR_LSB +: FIELD_W]);
            else
              time_out[MIN_LSB +: FIELD_W] <= inc_minutes(time_out[MIN_LSB +: FIELD_W]);
          end else if (idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
            state     <= RUN;
            setting   <= 1'b0;
            blank     <= 6'b000000;
            idle_cnt  <= 32'd0;
            blink_cnt <= 24'd0;
            phase     <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
            blank    <= blank_mask(state, phase_next);
          end
        end
        COMMIT: begin
          state     <= RUN;
          setting   <= 1'b0;
          blank     <= 6'b000000;
          blink_cnt <= 24'd0;
          phase     <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed bench for clock_time_setter with short debounce/blink/timeout.
module tb_clock_time_setter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [23:0] time_in = 24'h000000;
  logic [23:0] time_out;
  logic        load;
  logic        setting;
  logic [5:0]  blank;

  int passes = 0;
  int total = 0;
  int load_cnt = 0;

  clock_time_setter #(
    .DEBOUNCE_CYCLES(16'd4),
    .BLINK_DIV(24'd8),
    .TIMEOUT_CYCLES(32'd200)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .time_in(time_in), .time_out(time_out), .load(load),
    .setting(setting), .blank(blank)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_mode();
    btn_mode = 1'b1;
    tick(7);
  endtask

  task automatic push_inc();
    btn_inc = 1'b1;
    tick(7);
  endtask

  task automatic release_all();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(7);
  endtask

  task automatic tap_mode();
    push_mode();
    release_all();
  endtask

  task automatic inc_n(input int n);
    for (int i = 0; i < n; i++) begin
      push_inc();
      release_all();
    end
  endtask

  initial begin
    // Reset state
    time_in = 24'h134527;
    tick(2);
    chk("rst_time_out", time_out, 24'h000000);
    chk("rst_load", load, 1'b0);
    chk("rst_setting", setting, 1'b0);
    chk("rst_blank", blank, 6'b000000);
    rst = 1'b1;
    tick(2);

    // Basic edit 13:45 -> 15:00
    push_mode();
    chk("basic_setting", setting, 1'b1);
    chk("basic_capture", time_out, 24'h134500);
    chk("basic_blank_entry", blank, 6'b000000);
    release_all();
    inc_n(2);
    chk("basic_hr_inc2", time_out, 24'h154500);
    tap_mode();
    inc_n(14);
    chk("basic_min_59", time_out, 24'h155900);
    inc_n(1);
    chk("basic_min_wrap", time_out, 24'h150000);
    push_mode();
    chk("basic_load_hi", load, 1'b1);
    chk("basic_commit_val", time_out, 24'h150000);
    tick(1);
    chk("basic_load_lo", load, 1'b0);
    chk("basic_setting_lo", setting, 1'b0);
    chk("basic_load_cnt", load_cnt, 1);
    release_all();

    // Hour wrap 22 -> 23 -> 00
    time_in = 24'h223344;
    tap_mode();
    chk("wrap22_capture", time_out, 24'h223300);
    inc_n(1);
    chk("wrap_23", time_out, 24'h233300);
    inc_n(1);
    chk("wrap_00", time_out, 24'h003300);
    tap_mode();
    push_mode();
    chk("wrap_commit_load", load, 1'b1);
    chk("wrap_commit_val", time_out, 24'h003300);
    release_all();

    // 09 -> 10
    time_in = 24'h095959;
    tap_mode();
    chk("h09_capture", time_out, 24'h095900);
    inc_n(1);
    chk("h09_to_10", time_out, 24'h105900);
    tap_mode();
    tap_mode();
    chk("h09_load_cnt", load_cnt, 3);

    // 19 -> 20 with debounce checks
    time_in = 24'h191000;
    tap_mode();
    for (int g = 0; g < 2; g++) begin
      btn_inc = 1'b1;
      tick(3);
      btn_inc = 1'b0;
      tick(10);
    end
    chk("glitch_no_inc", time_out, 24'h191000);
    btn_inc = 1'b1;
    tick(6);
    chk("deb_before_inc", time_out, 24'h191000);
    tick(1);
    chk("deb_19_to_20", time_out, 24'h201000);
    tick(30);
    chk("deb_hold_no_repeat", time_out, 24'h201000);
    release_all();

    // Simultaneous mode+inc in SET_HR: mode wins
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    tick(7);
    chk("simul_hours_kept", time_out, 24'h201000);
    chk("simul_setting", setting, 1'b1);
    release_all();
    inc_n(1);
    chk("simul_now_min", time_out, 24'h201100);
    push_mode();
    chk("simul_commit_load", load, 1'b1);
    chk("simul_commit_val", time_out, 24'h201100);
    release_all();
    chk("simul_load_cnt", load_cnt, 4);

    // Timeout and blink in SET_HR
    time_in = 24'h081530;
    push_mode();
    btn_mode = 1'b0;
    chk("blink_entry", blank, 6'b000000);
    tick(7);
    chk("blink_e7", blank, 6'b000000);
    tick(1);
    chk("blink_e8", blank, 6'b110000);
    tick(7);
    chk("blink_e15", blank, 6'b110000);
    tick(1);
    chk("blink_e16", blank, 6'b000000);
    tick(8);
    chk("blink_e24", blank, 6'b110000);
    tick(175);
    chk("timeout_e199_setting", setting, 1'b1);
    tick(1);
    chk("timeout_setting", setting, 1'b0);
    chk("timeout_blank", blank, 6'b000000);
    chk("timeout_no_load", load_cnt, 4);
    chk("timeout_time_held", time_out, 24'h081500);
    tick(5);

    // Reset mid SET_MIN with a pending commit
    time_in = 24'h124000;
    tap_mode();
    inc_n(1);
    tap_mode();
    inc_n(1);
    chk("rstmid_edit", time_out, 24'h134100);
    btn_mode = 1'b1;
    tick(3);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_setting", setting, 1'b0);
    chk("rstmid_time_out", time_out, 24'h000000);
    chk("rstmid_blank", blank, 6'b000000);
    chk("rstmid_load", load, 1'b0);
    tick(3);
    btn_mode = 1'b0;
    rst = 1'b1;
    tick(20);
    chk("rstmid_no_load", load_cnt, 4);
    chk("rstmid_run", setting, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
